// File: rtl/b_io_l3_in_serialize_b_s_axi_rd_responder.sv
// -----------------------------------------------------------------------------
// b_io_l3_in_serialize_b_s_axi_rd_responder
//
// AXI4 read-channel responder (slave end) for the serialize_B m_axi read path.
// It accepts one AR request at a time and returns an INCR burst on R from a
// local word-addressed memory. A side write port lets a bench preload memory.
// Beats whose word index falls outside the memory return SLVERR with zero data.
// The burst carries on past such beats.
//
// Ports
//   clk, reset         clock (rising edge), synchronous active-high reset
//   s_ar*              AR channel: araddr (byte), arid, arlen (beats-1),
//                      arvalid / arready
//   s_r*               R channel: rdata, rid, rresp, rlast, rvalid / rready
//   mem_we/waddr/wdata preload write port, accepted in any state
// -----------------------------------------------------------------------------
module b_io_l3_in_serialize_b_s_axi_rd_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int MEM_AW     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  // AR channel
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [7:0]            s_arlen,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  // R channel
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  // Preload port
  input  logic                  mem_we,
  input  logic [MEM_AW-1:0]     mem_waddr,
  input  logic [DATA_WIDTH-1:0] mem_wdata
);

  // Byte offset bits within one data word. The word index keeps every
  // remaining address bit, so running past the memory end is detected rather
  // than wrapped.
  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W      = ADDR_WIDTH - BYTE_SHIFT;
  localparam int MEM_DEPTH  = 1 << MEM_AW;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                state_q,   state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q,  rvalid_d;
  logic                  rlast_q,   rlast_d;
  logic [1:0]            rresp_q,   rresp_d;
  logic [ID_WIDTH-1:0]   rid_q,     rid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [IDX_W-1:0]      idx_q,     idx_d;    // word index of the beat on R
  logic [7:0]            rem_q,     rem_d;    // beats left after the one on R

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------------------------------------------------------------------
  // Preload write port
  // ---------------------------------------------------------------------------
  // NOTE: the memory array has no reset. Contents are only defined by preload
  // writes, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Beat fetch
  // The word that will be on R after the next edge. In IDLE this is the start
  // word of a new request. In BURST it is the word after the current beat.
  // The fetch result is captured into rdata_q at the same edge as any preload
  // write, so a same-cycle write to that word is not seen (read-before-write).
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]      fetch_idx;
  logic                  fetch_ok;
  logic [DATA_WIDTH-1:0] fetch_data;

  always_comb begin
    if (state_q == S_IDLE) begin
      fetch_idx = s_araddr[ADDR_WIDTH-1:BYTE_SHIFT];
    end else begin
      fetch_idx = idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    // Any bit set at or above MEM_AW means the word is past the memory end.
    fetch_ok   = ~|fetch_idx[IDX_W-1:MEM_AW];
    fetch_data = fetch_ok ? mem[fetch_idx[MEM_AW-1:0]] : '0;
  end

  // Byte-lane bits of araddr are ignored: every access is full width.
  if (BYTE_SHIFT > 0) begin : g_addr_lsbs
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = |s_araddr[BYTE_SHIFT-1:0];
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default assignment first. That
  // keeps the block purely combinational, with no latch inferred on the paths
  // that do not assign it.
  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    idx_d     = idx_q;
    rem_d     = rem_q;

    unique case (state_q)
      S_IDLE: begin
        // arready rises on the first edge out of reset and stays up while idle.
        arready_d = 1'b1;
        if (s_arvalid && arready_q) begin
          state_d   = S_BURST;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rid_d     = s_arid;
          idx_d     = fetch_idx;
          rem_d     = s_arlen;
          rlast_d   = (s_arlen == 8'd0);
          rdata_d   = fetch_data;
          rresp_d   = fetch_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end

      S_BURST: begin
        // Without a handshake every R field holds, so stalls are stable.
        if (rvalid_q && s_rready) begin
          if (rlast_q) begin
            // Last beat accepted: drop R and reopen AR on the next cycle.
            state_d   = S_IDLE;
            arready_d = 1'b1;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
          end else begin
            // Present the next beat with no bubble.
            idx_d   = fetch_idx;
            rem_d   = rem_q - 8'd1;
            rlast_d = (rem_q == 8'd1);
            rdata_d = fetch_data;
            rresp_d = fetch_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together at the edge, whatever order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (reset) begin
      // A burst in flight is abandoned. No partial rlast is ever produced.
      state_q   <= S_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      rdata_q   <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: straight from registers
  // ---------------------------------------------------------------------------
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rlast   = rlast_q;
  assign s_rresp   = rresp_q;
  assign s_rid     = rid_q;
  assign s_rdata   = rdata_q;

endmodule
